// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM and a
// show-ahead byte FIFO with framing-error and overflow pulses.
module uart_rx #(
  parameter int UART_CLK_DIV = 868,
  parameter int FIFO_ASIZE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  output logic       rvalid,
  input  logic       rreq,
  output logic [7:0] rdata,
  output logic       frame_err,
  output logic       overflow
);

  localparam int P     = 2 * UART_CLK_DIV;
  localparam int CW    = $clog2(P);
  localparam int DEPTH = 1 << FIFO_ASIZE;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic                  sync1, rx_s;
  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [2:0]            bitn;
  logic [7:0]            shreg;
  logic [FIFO_ASIZE:0]   wptr, rptr;
  logic [7:0]            mem [DEPTH];
  logic                  full, empty, tick, stop_hit, push, pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      rx_s  <= sync1;
    end
  end

  // tick marks the middle of a data/stop bit once the start bit has been centred
  assign tick     = (cnt == CW'(P - 1));
  assign stop_hit = (state == S_STOP) && tick;
  assign push     = stop_hit && rx_s && !full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          bitn <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == CW'(UART_CLK_DIV - 1)) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt <= '0;
            if (rx_s) begin
              overflow <= full;
              state    <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // full is taken before any same-cycle pop, so a push into a full FIFO overflows
  assign empty  = (wptr == rptr);
  assign full   = (wptr[FIFO_ASIZE] != rptr[FIFO_ASIZE]) &&
                  (wptr[FIFO_ASIZE-1:0] == rptr[FIFO_ASIZE-1:0]);
  assign rvalid = !empty;
  assign pop    = rvalid && rreq;
  assign rdata  = rvalid ? mem[rptr[FIFO_ASIZE-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_ASIZE-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level reference model (byte queue plus scheduled
// stop-bit events) compared against the DUT every cycle, plus directed pins.
module tb_uart_rx;
  localparam int DIV  = 4;
  localparam int ASZ  = 2;
  localparam int P    = 2 * DIV;
  localparam int D    = 1 << ASZ;
  localparam int SOFF = 2 + DIV + 9 * P;   // pin start edge -> stop-bit sample cycle

  logic       clk = 0, rst_n = 0, pin = 1, rreq = 0;
  logic       rvalid, frame_err, overflow;
  logic [7:0] rdata;

  uart_rx #(.UART_CLK_DIV(DIV), .FIFO_ASIZE(ASZ)) dut (
    .clk(clk), .rst_n(rst_n), .i_uart_rx(pin), .rvalid(rvalid), .rreq(rreq),
    .rdata(rdata), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0, fe_seen = 0, ovf_seen = 0, mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // reference model: stop-bit outcome per frame, applied on its sample cycle
  logic [7:0] q[$];
  logic [8:0] ev[int];
  logic       m_fe = 0, m_ovf = 0;

  always @(posedge clk) begin
    bit popn, fl;
    m_fe = 0; m_ovf = 0;
    if (!rst_n) begin
      q.delete(); ev.delete();
    end else begin
      popn = rreq && (q.size() > 0);
      fl   = (q.size() == D);
      if (popn) void'(q.pop_front());
      if (ev.exists(cyc)) begin
        if (ev[cyc][8]) begin
          if (fl) m_ovf = 1; else q.push_back(ev[cyc][7:0]);
        end else m_fe = 1;
        ev.delete(cyc);
      end
    end
  end

  always @(negedge clk) begin
    logic       ev_v;
    logic [7:0] ev_d;
    if (cyc >= 1) begin
      ev_v = (q.size() > 0);
      ev_d = ev_v ? q[0] : 8'h00;
      chk("rvalid", rvalid, ev_v);
      chk("rdata", rdata, ev_d);
      chk("frame_err", frame_err, m_fe);
      chk("overflow", overflow, m_ovf);
      if (frame_err === 1'b1) fe_seen++;
      if (overflow === 1'b1) ovf_seen++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (mode)
      0: rreq = 0;
      1: rreq = 1;
      2: rreq = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(input int n); pin = 1; repeat (n) tick(); endtask

  task automatic send(input logic [7:0] b, input logic stopb, input int hold_low);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    ev[cyc + SOFF] = {stopb, b};
    for (int i = 0; i < 10; i++) begin pin = bits[i]; repeat (P) tick(); end
    if (hold_low > 0) begin pin = 0; repeat (hold_low) tick(); end
    pin = 1;
  endtask

  task automatic glitch(input int g);
    pin = 0; repeat (g) tick(); pin = 1; repeat (2 * P) tick();
  endtask

  initial begin
    int c0, lat, c5, f0, o0;
    logic [7:0] first;
    rst_n = 0; pin = 1; repeat (3) tick();
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 8'h00);
    rst_n = 1; tick();

    // back-to-back frames, latency pin
    mode = 1; lat = -1; first = 8'hxx; c0 = cyc;
    fork
      begin send(8'h55, 1, 0); send(8'hA3, 1, 0); end
      begin
        for (int i = 0; i < 200 && lat < 0; i++) begin
          @(negedge clk);
          if (rvalid === 1'b1) begin lat = cyc - c0; first = rdata; end
        end
      end
    join
    chk("t1_latency", lat, 79);
    chk("t1_first", first, 8'h55);
    idle(20);

    // short glitch rejected
    f0 = fe_seen; o0 = ovf_seen;
    glitch(3); send(8'h3C, 1, 0); idle(10);
    chk("t2_noerr", (fe_seen - f0) + (ovf_seen - o0), 0);

    // bad stop bit followed by a break
    mode = 0; f0 = fe_seen;
    send(8'h7E, 0, 4 * P); idle(10); send(8'h12, 1, 0); idle(5);
    chk("t3_fe_once", fe_seen - f0, 1);
    chk("t3_head", {rvalid, rdata}, {1'b1, 8'h12});
    chk("t3_model_cnt", q.size(), 1);
    mode = 1; idle(5);

    // fill to full, then overflow
    mode = 0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1, 0);
    idle(2);
    chk("t4_full_head", {rvalid, rdata}, {1'b1, 8'h01});
    o0 = ovf_seen;
    send(8'h05, 1, 0); idle(2);
    chk("t4_ovf_once", ovf_seen - o0, 1);
    mode = 3;
    for (int i = 1; i <= 4; i++) begin
      chk("t4_pop", rdata, i);
      rreq = 1; tick(); rreq = 0;
    end
    chk("t4_empty", rvalid, 0);

    // pop in the exact cycle of an overflowing stop sample
    mode = 0;
    for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), 1, 0);
    idle(2);
    mode = 3; o0 = ovf_seen; c5 = cyc;
    fork
      send(8'h15, 1, 0);
      begin
        while (cyc < c5 + SOFF) tick();
        rreq = 1; tick(); rreq = 0;
      end
    join
    idle(2);
    chk("t5_ovf", ovf_seen - o0, 1);
    chk("t5_model_cnt", q.size(), 3);
    chk("t5_head", rdata, 8'h12);
    mode = 1; idle(6);

    // reset mid-frame with bytes queued
    mode = 0; f0 = fe_seen;
    send(8'h21, 1, 0); send(8'h22, 1, 0); idle(2);
    pin = 0; repeat (P) tick();
    pin = 0; repeat (P) tick();        // 0x9A bit0
    pin = 1; repeat (P) tick();        // bit1
    pin = 0; repeat (P / 2) tick();    // bit2, interrupted
    rst_n = 0; pin = 1; tick(); rst_n = 1;
    chk("t6_rvalid", rvalid, 0);
    chk("t6_rdata", rdata, 8'h00);
    idle(3 * P); send(8'h66, 1, 0); idle(2);
    chk("t6_head", {rvalid, rdata}, {1'b1, 8'h66});
    chk("t6_no_fe", fe_seen - f0, 0);
    mode = 1; idle(5);

    // randomized traffic
    mode = 2;
    for (int n = 0; n < 60; n++) begin
      int r;
      bit bad;
      r = $urandom_range(0, 99);
      if (r < 10) glitch($urandom_range(1, DIV - 1));
      bad = (r >= 90);
      send(8'($urandom), !bad, bad ? $urandom_range(0, 2 * P) : 0);
      if (bad) idle($urandom_range(4, 20));
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
    end
    mode = 1; idle(20);
    chk("end_drained", rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
